// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared ALU op encodings, width and command type
package alu_pkg;

    localparam int ALU_W = 8;

    localparam logic [2:0] OP_ADD = 3'b000;
    localparam logic [2:0] OP_SUB = 3'b001;
    localparam logic [2:0] OP_SLL = 3'b010;
    localparam logic [2:0] OP_LSR = 3'b011;
    localparam logic [2:0] OP_AND = 3'b100;
    localparam logic [2:0] OP_OR  = 3'b101;
    localparam logic [2:0] OP_XOR = 3'b110;
    localparam logic [2:0] OP_EQL = 3'b111;

    typedef struct packed {
        logic [ALU_W-1:0] a;
        logic [ALU_W-1:0] b;
        logic [2:0]       op;
    } alu_cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous command FIFO with push/pop and occupancy count
module alu_cmd_fifo #(
    parameter  int DEPTH = 4,
    parameter  int EW    = 19,
    localparam int AW    = $clog2(DEPTH),
    localparam int CW    = AW + 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          push_i,
    input  logic [EW-1:0] push_data_i,
    input  logic          pop_i,
    output logic [EW-1:0] pop_data_o,
    output logic [CW-1:0] count_o,
    output logic          full_o,
    output logic          empty_o
);

    logic [EW-1:0] r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;

    // Callers only push when not full and pop when not empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (push_i)
                r_wr_ptr <= r_wr_ptr + AW'(1);
            if (pop_i)
                r_rd_ptr <= r_rd_ptr + AW'(1);
            case ({push_i, pop_i})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (push_i)
            r_mem[r_wr_ptr] <= push_data_i;
    end

    assign pop_data_o = r_mem[r_rd_ptr];
    assign count_o    = r_count;
    assign full_o     = (r_count == CW'(DEPTH));
    assign empty_o    = (r_count == '0);

endmodule

// File: rtl/alu_issue_stage.sv
// rtl/alu_issue_stage.sv - FIFO-buffered issue slot driving an external ALU, plus result slot
module alu_issue_stage
    import alu_pkg::*;
#(
    parameter  int DEPTH = 4,
    parameter  int WIDTH = ALU_W,
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid_i,
    output logic             cmd_ready_o,
    input  logic [WIDTH-1:0] cmd_a_i,
    input  logic [WIDTH-1:0] cmd_b_i,
    input  logic [2:0]       cmd_op_i,
    output logic [WIDTH-1:0] alu_a_o,
    output logic [WIDTH-1:0] alu_b_o,
    output logic [2:0]       alu_op_o,
    input  logic [WIDTH-1:0] alu_res_i,
    output logic             res_valid_o,
    input  logic             res_ready_i,
    output logic [WIDTH-1:0] res_data_o,
    output logic [2:0]       res_op_o,
    output logic             res_zero_o,
    output logic [CW-1:0]    count_o
);

    localparam int EW = 2 * WIDTH + 3;

    logic [EW-1:0] w_head;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic          w_res_load;

    logic             r_iss_vld;
    logic [WIDTH-1:0] r_alu_a;
    logic [WIDTH-1:0] r_alu_b;
    logic [2:0]       r_alu_op;
    logic             r_res_vld;
    logic [WIDTH-1:0] r_res_data;
    logic [2:0]       r_res_op;
    logic             r_res_zero;

    // Ready comes from the registered count only, so a full FIFO never bypasses a same-cycle pop.
    assign cmd_ready_o = !w_full;
    assign w_push      = cmd_valid_i && cmd_ready_o;
    assign w_res_load  = r_iss_vld && (!r_res_vld || res_ready_i);
    assign w_pop       = !w_empty && (!r_iss_vld || w_res_load);

    alu_cmd_fifo #(
        .DEPTH (DEPTH),
        .EW    (EW)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_i      (w_push),
        .push_data_i ({cmd_a_i, cmd_b_i, cmd_op_i}),
        .pop_i       (w_pop),
        .pop_data_o  (w_head),
        .count_o     (count_o),
        .full_o      (w_full),
        .empty_o     (w_empty)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_iss_vld <= 1'b0;
            r_alu_a   <= '0;
            r_alu_b   <= '0;
            r_alu_op  <= 3'b000;
        end else if (w_pop) begin
            r_iss_vld <= 1'b1;
            r_alu_a   <= w_head[EW-1 -: WIDTH];
            r_alu_b   <= w_head[EW-WIDTH-1 -: WIDTH];
            r_alu_op  <= w_head[2:0];
        end else if (w_res_load) begin
            r_iss_vld <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_res_vld  <= 1'b0;
            r_res_data <= '0;
            r_res_op   <= 3'b000;
            r_res_zero <= 1'b0;
        end else if (w_res_load) begin
            r_res_vld  <= 1'b1;
            r_res_data <= alu_res_i;
            r_res_op   <= r_alu_op;
            r_res_zero <= (alu_res_i == '0);
        end else if (r_res_vld && res_ready_i) begin
            r_res_vld  <= 1'b0;
        end
    end

    assign alu_a_o     = r_alu_a;
    assign alu_b_o     = r_alu_b;
    assign alu_op_o    = r_alu_op;
    assign res_valid_o = r_res_vld;
    assign res_data_o  = r_res_data;
    assign res_op_o    = r_res_op;
    assign res_zero_o  = r_res_zero;

endmodule

// File: doc/alu_issue_stage.md
# alu_issue_stage

Upstream issue stage for the 8-bit combinational ALU (ADD/SUB/SLL/LSR/AND/OR/XOR/EQL).
- Accepts ALU commands over a valid/ready interface and buffers them in a small FIFO.
- Drives one command at a time into the ALU from a registered issue slot.
- Captures the ALU result, with op and zero flag, into a registered output slot with its own valid/ready handshake.
- The ALU is instantiated beside this block in the parent; this block only drives its operand/op inputs and samples its result.

## Interface
- DEPTH, 4: command FIFO entries; power of two, ≥ 2
- WIDTH, 8: operand/result width
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- cmd_valid_i  in  1  command offered
- cmd_ready_o  out  1  FIFO can accept; high iff count_o < DEPTH
- cmd_a_i  in  WIDTH  operand a
- cmd_b_i  in  WIDTH  operand b
- cmd_op_i  in  3  ALU encoding
- alu_a_o  out  WIDTH  registered operand a to ALU
- alu_b_o  out  WIDTH  registered operand b to ALU
- alu_op_o  out  3  registered op to ALU
- alu_res_i  in  WIDTH  combinational ALU result for current alu_*_o
- res_valid_o  out  1  result slot full
- res_ready_i  in  1  consumer takes result
- res_data_o  out  WIDTH  captured result
- res_op_o  out  3  op that produced res_data_o
- res_zero_o  out  1  res_data_o == 0
- count_o  out  $clog2(DEPTH)+1  FIFO occupancy (excludes issue and result slots)

## Operation
- Three storage levels: FIFO → issue slot (issue_vld, drives alu_*_o) → result slot (res_valid_o).
- Push: cmd_valid_i && cmd_ready_o at an edge writes {a,b,op} at the write pointer.
- Result capture (res_load): issue_vld && (!res_valid_o || res_ready_i).
  - Loads alu_res_i, alu_op_o, and zero flag; res_valid_o=1.
  - Else if res_valid_o && res_ready_i, then res_valid_o=0.
- Issue load (iss_load): FIFO non-empty && (!issue_vld || res_load).
  - Pops the head into alu_*_o; issue_vld=1.
  - Else if res_load, then issue_vld=0.
- Count update:
  - Push only: +1.
  - Pop only: −1.
  - Push and pop in the same cycle: unchanged.
- Full: cmd_ready_o derives from registered count. When full, ready is low even if a pop occurs the same cycle (no full-bypass).
- Empty FIFO: a push is not visible to the issue slot until the following edge (no bypass).
- Pointers wrap modulo DEPTH. Count distinguishes full from empty.
- Hold rules:
  - alu_*_o are stable while issue_vld && !res_load.
  - res_data_o, res_op_o, res_zero_o are stable while res_valid_o && !res_ready_i.
- Commands never drop, duplicate, or reorder.
- Zero flag: EQL false gives res_zero_o=1; EQL true (result 1) gives 0.

## Timing
- Reset (async assert, sync-released by parent) sets:
  - count_o=0, pointers=0, issue_vld=0, res_valid_o=0.
  - alu_a_o, alu_b_o, res_data_o = 0; alu_op_o, res_op_o = 3'b000; res_zero_o=0.
  - cmd_ready_o=1 after reset.
- Latency, empty pipe:
  - Command accepted at edge N.
  - Appears on alu_*_o after edge N+1.
  - res_valid_o with result after edge N+2.
- Throughput: 1 result/cycle with res_ready_i held high.
- Back-pressure: with res_ready_i low, pipe fills to DEPTH+2 commands, then cmd_ready_o=0.
- Reset mid-operation discards all buffered commands and results immediately.

## Structure
- Shared package alu_pkg holds:
  - Op localparams OP_ADD=3'b000, OP_SUB, OP_SLL, OP_LSR, OP_AND, OP_OR, OP_XOR, OP_EQL=3'b111.
  - ALU_W=8.
  - Packed command struct {a, b, op}.
- Sub-module alu_cmd_fifo is a synchronous FIFO with push/pop/count, parameterised by DEPTH and entry width. Issue and result slots stay in the top.

## Test plan
- Single ADD: a=8'h05, b=8'h03, op=000 at edge 0, res_ready_i=1 → res_valid_o after edge 2, res_data_o=8'h08, res_op_o=000, res_zero_o=0.
- Back-to-back stream: SUB 8'h10−8'h10, XOR 8'hAA^8'h55, EQL 8'h7E==8'h7E → results 8'h00 (zero=1), 8'hFF, 8'h01 on three consecutive cycles.
- Back-pressure: res_ready_i=0, push 7 commands with DEPTH=4:
  - cmd_ready_o falls after the 6th accept; count_o=4.
  - Release ready → all 6 results emerge in order; outputs held stable while stalled.
- Simultaneous push/pop at count_o=2 → count_o stays 2. At count_o=4 with a pop → cmd_ready_o still 0 that cycle.
- Wrap-around: 3×DEPTH commands with random ready toggling → scoreboard shows in-order, lossless results matching a reference ALU model.
- Reset mid-stream with 3 commands queued and res_valid_o=1 → all outputs go to reset values immediately. After release, a new AND 8'hF0&8'h3C yields 8'h30.
